// File: rtl/nms_stream_if.sv
// nms_stream_if -- stream bundle for the non-maximum-suppression block.
//
// Handshake: in_valid qualifies in_sof/in_data for exactly one cycle and
// there is no ready; the sink must take every valid pixel. out_valid marks a
// one-cycle result; out_flag/out_score/out_x/out_y hold their last value
// while out_valid is low. There is no backpressure on either side.
//
// Signals:
//   in_valid, in_sof, in_data   raster-order signed scores, sof marks (0,0)
//   threshold                   minimum accepted centre score
//   out_valid, out_flag         result strobe and local-maximum flag
//   out_score, out_x, out_y     centre score and coordinates
// Modports: master drives the input stream, slave is the NMS block.
interface nms_stream_if #(
  parameter int DATA_BITS    = 16,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
);
  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);

  logic                        in_valid;
  logic                        in_sof;
  logic signed [DATA_BITS-1:0] in_data;
  logic signed [DATA_BITS-1:0] threshold;
  logic                        out_valid;
  logic                        out_flag;
  logic signed [DATA_BITS-1:0] out_score;
  logic [XW-1:0]               out_x;
  logic [YW-1:0]               out_y;

  modport master (
    output in_valid, in_sof, in_data, threshold,
    input  out_valid, out_flag, out_score, out_x, out_y
  );

  modport slave (
    input  in_valid, in_sof, in_data, threshold,
    output out_valid, out_flag, out_score, out_x, out_y
  );
endinterface

// File: rtl/nms_stream.sv
// nms_stream -- streaming non-maximum suppression over a square window.
//
// Pixels arrive in raster order. WINDOW_SIZE-1 line buffers feed a
// WINDOW_SIZE x WINDOW_SIZE window register. Once a pixel at (x,y) with
// x>=2R and y>=2R is accepted, the window centred at (x-R,y-R) is complete;
// the next cycle evaluates it and registers the result, so out_valid rises
// two cycles after the completing pixel was presented.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   s     nms_stream_if.slave (input stream, threshold, result stream)
module nms_stream #(
  parameter int DATA_BITS    = 16,
  parameter int WINDOW_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic         clk,
  input  logic         rst,
  nms_stream_if.slave  s
);
  localparam int N  = WINDOW_SIZE;
  localparam int R  = WINDOW_SIZE / 2;
  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);

  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(2 * R);
  localparam logic [YW-1:0] Y_MIN  = YW'(2 * R);

  typedef logic signed [DATA_BITS-1:0] data_t;

  // Position counters (coordinates of the next expected pixel)
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] w_px;
  logic [YW-1:0] w_py;
  logic          w_complete;

  // Storage: r_lb[k][x] holds the pixel of row (y-1-k) at column x.
  data_t r_lb  [N-1][IMAGE_WIDTH];
  // r_win[row][col]: row 0 is the oldest line, col N-1 the newest column.
  data_t r_win [N][N];
  data_t w_col [N];

  // Stage 1: window just completed
  logic          r_s1_valid;
  logic [XW-1:0] r_s1_x;
  logic [YW-1:0] r_s1_y;
  data_t         r_s1_thr;

  // Stage 2: registered result
  logic          r_out_valid;
  logic          r_out_flag;
  data_t         r_out_score;
  logic [XW-1:0] r_out_x;
  logic [YW-1:0] r_out_y;

  data_t         w_centre;
  logic          w_flag;

  // A start-of-frame pixel is (0,0) whatever the counters say, so the row
  // gating below restarts and no window mixes lines from the old frame.
  always_comb begin
    w_px       = s.in_sof ? '0 : r_x;
    w_py       = s.in_sof ? '0 : r_y;
    w_complete = s.in_valid && (w_px >= X_MIN) && (w_py >= Y_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (s.in_valid) begin
      if (w_px == X_LAST) begin
        r_x <= '0;
        r_y <= (w_py == Y_LAST) ? '0 : w_py + YW'(1);
      end else begin
        r_x <= w_px + XW'(1);
        r_y <= w_py;
      end
    end
  end

  // Vertical column for the current x: index k is the pixel of row (y-k).
  always_comb begin
    w_col[0] = s.in_data;
    for (int k = 0; k < N - 1; k++) begin
      w_col[k+1] = r_lb[k][w_px];
    end
  end

  // Line buffers and window are data-only and need no reset: the counter
  // gating ensures no result is built from contents older than y=0.
  // Because completion requires x>=2R, the N columns in the window always
  // come from the same line; a wrap never reaches a completed window.
  always_ff @(posedge clk) begin
    if (s.in_valid) begin
      for (int k = 0; k < N - 1; k++) begin
        r_lb[k][w_px] <= w_col[k];
      end
      for (int j = 0; j < N; j++) begin
        for (int i = 0; i < N - 1; i++) begin
          r_win[j][i] <= r_win[j][i+1];
        end
        r_win[j][N-1] <= w_col[N-1-j];
      end
    end
  end

  // Threshold is captured with the completing pixel so later changes on the
  // input do not affect a window already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_thr   <= '0;
    end else begin
      r_s1_valid <= w_complete;
      if (w_complete) begin
        r_s1_x   <= w_px - XW'(R);
        r_s1_y   <= w_py - YW'(R);
        r_s1_thr <= s.threshold;
      end
    end
  end

  // Tie-break: neighbours that precede the centre in raster order must be
  // strictly smaller, later ones may be equal. Of two equal peaks only the
  // first in raster order is flagged.
  assign w_centre = r_win[R][R];

  always_comb begin
    w_flag = (w_centre >= r_s1_thr);
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if ((j < R) || ((j == R) && (i < R))) begin
          if (!(r_win[j][i] < w_centre)) w_flag = 1'b0;
        end else if (!((j == R) && (i == R))) begin
          if (r_win[j][i] > w_centre) w_flag = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_flag  <= 1'b0;
      r_out_score <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_flag  <= w_flag;
        r_out_score <= w_centre;
        r_out_x     <= r_s1_x;
        r_out_y     <= r_s1_y;
      end
    end
  end

  assign s.out_valid = r_out_valid;
  assign s.out_flag  = r_out_flag;
  assign s.out_score = r_out_score;
  assign s.out_x     = r_out_x;
  assign s.out_y     = r_out_y;
endmodule

// File: tb/tb_nms_stream.sv
// tb_nms_stream -- directed bench for nms_stream on an 8x6 image, 3x3 window.
module tb_nms_stream;
  localparam int DB = 16;
  localparam int WS = 3;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int W  = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nms_stream_if #(.DATA_BITS(DB), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)) bus ();

  nms_stream #(
    .DATA_BITS(DB), .WINDOW_SIZE(WS), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  // Entry: [63:40] expected sample edge, [39:32] x, [31:24] y,
  //        [16] flag, [15:0] score
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic [W-1:0] last_e = '0;
  int n_vec = 0;
  int n_err = 0;
  int res_cnt = 0;
  int flag_cnt = 0;
  int flag_base = 0;
  int ffx = -1;
  int ffy = -1;

  logic signed [15:0] img [IH][IW];
  logic signed [15:0] thr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: centre >= threshold, neighbours earlier in raster order
  // strictly below the centre, later ones not above it.
  function automatic logic model_flag(input int cx, input int cy, input logic signed [15:0] t);
    logic signed [15:0] c;
    logic signed [15:0] n;
    logic f;
    c = img[cy][cx];
    f = (c >= t);
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx == 0 && dy == 0) continue;
        n = img[cy+dy][cx+dx];
        if ((cy + dy) * IW + (cx + dx) < cy * IW + cx) begin
          if (!(n < c)) f = 1'b0;
        end else begin
          if (n > c) f = 1'b0;
        end
      end
    end
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = 16'($urandom);
    bus.threshold = 16'($urandom);
  endtask

  task automatic send_frame(input int npix, input bit gaps);
    int x;
    int y;
    for (int p = 0; p < npix; p++) begin
      if (gaps) repeat ($urandom_range(0, 2)) idle();
      @(posedge clk); #1;
      x = p % IW;
      y = p / IW;
      bus.in_valid  = 1'b1;
      bus.in_sof    = (p == 0);
      bus.in_data   = img[y][x];
      bus.threshold = thr;
      if (x >= 2 && y >= 2) begin
        exp_q.push_back({24'(edge_n + 2), 8'(x - 1), 8'(y - 1), 7'b0,
                         model_flag(x - 1, y - 1, thr), img[y-1][x-1]});
      end
    end
    idle();
  endtask

  task automatic fill(input logic signed [15:0] v);
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++)
        img[y][x] = v;
  endtask

  task automatic start_test();
    flag_base = flag_cnt;
    res_cnt   = 0;
  endtask

  task automatic finish_test(input int nres, input int nflag, input int fx, input int fy);
    repeat (5) idle();
    check("drain", exp_q.size(), 0);
    check("n_results", res_cnt, nres);
    check("n_flags", flag_cnt - flag_base, nflag);
    if (nflag > 0) begin
      check("first_flag_x", ffx, fx);
      check("first_flag_y", ffy, fy);
    end
  endtask

  task automatic reset_checks();
    check("rst_valid", bus.out_valid, 0);
    check("rst_flag",  bus.out_flag, 0);
    check("rst_score", {bus.out_score}, 0);
    check("rst_x",     bus.out_x, 0);
    check("rst_y",     bus.out_y, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      last_e = '0;
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", bus.out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("latency", edge_n, e[63:40]);
        check("x",       bus.out_x, e[39:32]);
        check("y",       bus.out_y, e[31:24]);
        check("flag",    bus.out_flag, e[16]);
        check("score",   {bus.out_score}, e[15:0]);
        last_e = e;
      end
      res_cnt++;
      if (bus.out_flag) begin
        flag_cnt++;
        if (flag_cnt == flag_base + 1) begin
          ffx = int'(bus.out_x);
          ffy = int'(bus.out_y);
        end
      end
    end else begin
      check("hold", {bus.out_flag, bus.out_score, bus.out_x, bus.out_y},
            {last_e[16], last_e[15:0], last_e[34:32], last_e[26:24]});
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = '0;
    bus.threshold = '0;
    thr = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst = 1'b0;

    // all zeros, threshold 1: 24 results, no flags
    fill(16'sd0); thr = 16'sd1;
    start_test(); send_frame(48, 1'b0); finish_test(24, 0, 0, 0);

    // single peak at (3,2)
    fill(16'sd0); img[2][3] = 16'sd100; thr = 16'sd50;
    start_test(); send_frame(48, 1'b0); finish_test(24, 1, 3, 2);

    // same peak, threshold above it
    thr = 16'sd101;
    start_test(); send_frame(48, 1'b0); finish_test(24, 0, 0, 0);

    // equal peaks (3,2),(4,3): the earlier one wins
    fill(16'sd0); img[2][3] = 16'sd100; img[3][4] = 16'sd100; thr = 16'sd50;
    start_test(); send_frame(48, 1'b0); finish_test(24, 1, 3, 2);

    // equal peaks (3,2),(2,1): the earlier one wins
    fill(16'sd0); img[2][3] = 16'sd100; img[1][2] = 16'sd100; thr = 16'sd50;
    start_test(); send_frame(48, 1'b0); finish_test(24, 1, 2, 1);

    // signed scores
    fill(-16'sd5); img[2][4] = -16'sd1; thr = -16'sd2;
    start_test(); send_frame(48, 1'b0); finish_test(24, 1, 4, 2);

    // single peak with random input gaps
    fill(16'sd0); img[2][3] = 16'sd100; thr = 16'sd50;
    start_test(); send_frame(48, 1'b1); finish_test(24, 1, 3, 2);

    // reset after 20 pixels, then a fresh frame
    start_test();
    send_frame(20, 1'b0);
    repeat (3) idle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(48, 1'b0);
    finish_test(26, 1, 3, 2);

    // sof mid-frame: 30 pixels of the signed frame, then a new frame
    fill(-16'sd5); img[2][4] = -16'sd1; thr = -16'sd2;
    start_test();
    send_frame(30, 1'b0);
    fill(16'sd0); img[2][3] = 16'sd100; img[3][4] = 16'sd100; thr = 16'sd50;
    send_frame(48, 1'b0);
    finish_test(34, 2, 4, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
